// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux, register array with same-cycle write-through read ports, and retired-write counter
module wb_regfile #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reg_write_en_i,
  input  logic              mem_to_reg_i,
  input  logic [ADDR_W-1:0] reg_write_addr_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [CNT_W-1:0]  wb_count_o
);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic [DATA_W-1:0] wb_sel;
  logic              we;
  assign wb_sel = mem_to_reg_i ? mem_data_i : alu_i;
  assign we = reg_write_en_i && !rst_i && !(ZERO_REG != 0 && reg_write_addr_i == '0);
  always_comb begin
    wb_data_o  = rst_i ? '0 : wb_sel;
    rs1_data_o = (rst_i || (ZERO_REG != 0 && rs1_addr_i == '0)) ? '0 :
                 (we && reg_write_addr_i == rs1_addr_i) ? wb_sel : regs[rs1_addr_i];
    rs2_data_o = (rst_i || (ZERO_REG != 0 && rs2_addr_i == '0)) ? '0 :
                 (we && reg_write_addr_i == rs2_addr_i) ? wb_sel : regs[rs2_addr_i];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      wb_count_o <= '0;
    end else if (we) begin
      regs[reg_write_addr_i] <= wb_sel;
      wb_count_o             <= wb_count_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed table, corner sequences and randomized traffic against an array-based reference model
module tb_wb_regfile;
  localparam int DW = 64, AW = 5, NR = 32;
  localparam logic [DW-1:0] D = 64'hDEAD_BEEF_0000_0001;
  logic clk = 0, rst = 1, en = 0, m2r = 0;
  logic [AW-1:0] wa = '0, ra1 = '0, ra2 = '0;
  logic [DW-1:0] alu = '0, mem = '0;
  logic [DW-1:0] rs1, rs2, wb, rs1_b, rs2_b, wb_b;
  logic [31:0] cnt;
  logic [3:0] cnt_b;
  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] mdl [NR];
  int unsigned m_cnt = 0;

  typedef struct {
    logic rst, en, m2r;
    logic [AW-1:0] wa, r1, r2;
    logic [DW-1:0] alu, mem, e1, e2, ewb;
    logic [31:0] ecnt;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk_i(clk), .rst_i(rst), .reg_write_en_i(en), .mem_to_reg_i(m2r),
    .reg_write_addr_i(wa), .alu_i(alu), .mem_data_i(mem),
    .rs1_addr_i(ra1), .rs2_addr_i(ra2),
    .rs1_data_o(rs1), .rs2_data_o(rs2), .wb_data_o(wb), .wb_count_o(cnt)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .reg_write_en_i(en), .mem_to_reg_i(m2r),
    .reg_write_addr_i(wa), .alu_i(alu), .mem_data_i(mem),
    .rs1_addr_i(ra1), .rs2_addr_i(ra2),
    .rs1_data_o(rs1_b), .rs2_data_o(rs2_b), .wb_data_o(wb_b), .wb_count_o(cnt_b)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    logic [DW-1:0] w = m2r ? mem : alu;
    if (rst || a == 0) return '0;
    if (en && wa == a && wa != 0) return w;
    return mdl[a];
  endfunction

  task automatic tick();
    #1;
    chk("rs1", rs1, m_rd(ra1));
    chk("rs2", rs2, m_rd(ra2));
    chk("wb", wb, rst ? '0 : (m2r ? mem : alu));
    chk("cnt", {32'h0, cnt}, 64'(m_cnt));
    chk("cnt4", 64'(cnt_b), 64'(m_cnt % 16));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      m_cnt = 0;
    end else if (en && wa != 0) begin
      mdl[wa] = m2r ? mem : alu;
      m_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, D, 'h0, D, 'h0, D, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 'h0, 'h0, D, D, 'h0, 1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 'h55, 'h1234, 'h1234, 'h1234, 'h1234, 1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd5, 'h0, 'h99, 'h1234, D, 'h99, 2};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 'hFFFF, 'h0, 'h0, 'h1234, 'hFFFF, 2};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 'h0, 'h0, 'h0, 'h0, 'h0, 2};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 5'd3, 5'd3, 5'd4, 'hAA, 'h0, 'hAA, 'h0, 'hAA, 2};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 5'd4, 5'd3, 5'd4, 'hBB, 'h0, 'h0, 'h0, 'h0, 3};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd4, 'h0, 'h0, 'h0, 'h0, 'h0, 0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd7, 'h0, 'h0, 'h0, 'h0, 'h0, 0};

    // Two reset cycles before anything is known, then reset-state sweep of every address
    repeat (2) @(posedge clk);
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    m_cnt = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < NR; i++) begin
      ra1 = AW'(i);
      ra2 = AW'(NR - 1 - i);
      tick();
    end

    for (int k = 0; k < 10; k++) begin
      {rst, en, m2r, wa, ra1, ra2, alu, mem} =
        {tbl[k].rst, tbl[k].en, tbl[k].m2r, tbl[k].wa, tbl[k].r1, tbl[k].r2, tbl[k].alu, tbl[k].mem};
      #1;
      chk($sformatf("tbl%0d_rs1", k), rs1, tbl[k].e1);
      chk($sformatf("tbl%0d_rs2", k), rs2, tbl[k].e2);
      chk($sformatf("tbl%0d_wb", k), wb, tbl[k].ewb);
      chk($sformatf("tbl%0d_cnt", k), {32'h0, cnt}, {32'h0, tbl[k].ecnt});
      tick();
    end

    // Counter wrap on the 4-bit instance
    rst = 1; en = 0;
    tick();
    rst = 0; en = 1; m2r = 0;
    for (int k = 0; k < 17; k++) begin
      wa = AW'($urandom_range(1, NR - 1));
      alu = {$urandom, $urandom};
      tick();
    end
    en = 0;
    #1;
    chk("wrap_cnt4", 64'(cnt_b), 64'd1);
    chk("wrap_cnt", {32'h0, cnt}, 64'd17);
    tick();

    // Back-to-back writes to reg 9
    en = 1; wa = 5'd9; ra1 = 5'd9; ra2 = 5'd9;
    for (int v = 1; v <= 3; v++) begin
      alu = DW'(v);
      #1;
      chk("b2b_rs1", rs1, DW'(v));
      chk("b2b_rs2", rs2, DW'(v));
      tick();
    end
    en = 0;
    #1;
    chk("b2b_final", rs1, 64'd3);
    tick();

    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 9) < 7);
      m2r = $urandom_range(0, 1) == 1;
      wa  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      alu = {$urandom, $urandom};
      mem = {$urandom, $urandom};
      ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
